// File: rtl/state_seq_pkg.sv
// Shared sequencer state encoding and helpers.
// Used by the sequencer and by state_seq_checker.
package state_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_START = 2'b01;
  localparam state_t ST_RUN   = 2'b10;
  localparam state_t ST_STOP  = 2'b11;

  function automatic state_t next_state(input state_t s);
    return state_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with clear and load-one.
// Ports: clk, rst (sync, high), inc, clr, load1, q[W-1:0].
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         load1,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_base;
  logic [W-1:0] w_next;

  // clr zeroes the base; inc/load1 then apply on top
  always_comb begin
    w_base = clr ? '0 : r_q;
    w_next = w_base;
    if (load1)
      w_next = W'(1);
    else if (inc && (w_base != '1))
      w_next = w_base + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= w_next;
  end

  assign q = r_q;

endmodule

// File: rtl/state_seq_checker.sv
// Checks a sequencer state stream for legal steps,
// counts laps, tracks dwell and flags errors/timeouts.
// Ports: clock, reset (sync, high), state_in, state_valid,
//   clear; outputs error, err_from, err_to, err_count,
//   lap_count, dwell, dwell_timeout.
// Option: STATE_SEQ_STRICT_EN makes holds illegal.
module state_seq_checker
  import state_seq_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_DWELL = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       state_in,
  input  logic             state_valid,
  input  logic             clear,
  output logic             error,
  output logic [1:0]       err_from,
  output logic [1:0]       err_to,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] lap_count,
  output logic [7:0]       dwell,
  output logic             dwell_timeout
);

  state_t           r_prev;
  logic             r_seen;
  logic             r_error;
  state_t           r_from;
  state_t           r_to;
  logic [CNT_W-1:0] r_lap;

  logic w_hold;
  logic w_adv;
  logic w_legal;
  logic w_ok;
  logic w_bad;
  logic w_lap;
  logic w_err_base;
  logic w_dw_inc;
  logic w_dw_load;

  always_comb begin
    w_hold = r_seen && (state_in == r_prev);
    // before the first sample only IDLE counts as a step
    w_adv  = r_seen ? (state_in == next_state(r_prev))
                    : (state_in == ST_IDLE);
`ifdef STATE_SEQ_STRICT_EN
    w_legal = w_adv;
`else
    w_legal = w_adv || w_hold;
`endif
    w_ok   = state_valid && w_legal;
    w_bad  = state_valid && !w_legal;
    w_lap  = w_ok && r_seen && (r_prev == ST_STOP)
          && (state_in == ST_IDLE);
    w_err_base = clear ? 1'b0 : r_error;
    w_dw_inc   = w_ok && w_hold;
    w_dw_load  = state_valid && !w_dw_inc;
  end

  seq_sat_counter #(.W(8)) u_dwell (
    .clk   (clock),
    .rst   (reset),
    .inc   (w_dw_inc),
    .clr   (1'b0),
    .load1 (w_dw_load),
    .q     (dwell)
  );

  seq_sat_counter #(.W(CNT_W)) u_errcnt (
    .clk   (clock),
    .rst   (reset),
    .inc   (w_bad),
    .clr   (clear),
    .load1 (1'b0),
    .q     (err_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev  <= ST_IDLE;
      r_seen  <= 1'b0;
      r_error <= 1'b0;
      r_from  <= ST_IDLE;
      r_to    <= ST_IDLE;
      r_lap   <= '0;
    end else begin
      if (state_valid) begin
        r_prev <= state_in;
        r_seen <= 1'b1;
      end
      r_error <= w_err_base || w_bad;
      if (clear) begin
        r_from <= ST_IDLE;
        r_to   <= ST_IDLE;
      end
      // only the first error since reset/clear is kept
      if (w_bad && !w_err_base) begin
        r_from <= r_prev;
        r_to   <= state_in;
      end
      r_lap <= (clear ? '0 : r_lap) + CNT_W'(w_lap);
    end
  end

`ifdef STATE_SEQ_STRICT_EN
  assign dwell_timeout = 1'b0;
`else
  logic w_tmo_set;
  logic r_tmo;

  assign w_tmo_set = w_dw_inc && (dwell == 8'(MAX_DWELL));

  always_ff @(posedge clock) begin
    if (reset) r_tmo <= 1'b0;
    else       r_tmo <= (clear ? 1'b0 : r_tmo) | w_tmo_set;
  end

  assign dwell_timeout = r_tmo;
`endif

  assign error     = r_error;
  assign err_from  = r_from;
  assign err_to    = r_to;
  assign lap_count = r_lap;

endmodule

// File: tb/tb_state_seq_checker.sv
// Self-checking bench for state_seq_checker: vector
// table, corner sequences and a randomized model run.
module tb_state_seq_checker;

  localparam int CW = 16;
  localparam int MD = 3;
  localparam int AW = 2*CW + 14;
`ifdef STATE_SEQ_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    state_in = 2'b00;
  logic          state_valid = 1'b0;
  logic          clear = 1'b0;
  logic          error;
  logic [1:0]    err_from;
  logic [1:0]    err_to;
  logic [CW-1:0] err_count;
  logic [CW-1:0] lap_count;
  logic [7:0]    dwell;
  logic          dwell_timeout;

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  state_seq_checker #(.CNT_W(CW), .MAX_DWELL(MD)) dut (
    .clock         (clock),
    .reset         (reset),
    .state_in      (state_in),
    .state_valid   (state_valid),
    .clear         (clear),
    .error         (error),
    .err_from      (err_from),
    .err_to        (err_to),
    .err_count     (err_count),
    .lap_count     (lap_count),
    .dwell         (dwell),
    .dwell_timeout (dwell_timeout)
  );

  typedef struct {
    bit       r;
    bit       v;
    bit       c;
    bit [1:0] s;
    bit       e;
    bit [1:0] ef;
    bit [1:0] et;
    int       ec;
    int       lap;
    int       dw;
    bit       to;
  } vec_t;

  vec_t tbl[$];

  // model state
  bit       m_e, m_to, m_seen;
  bit [1:0] m_ef, m_et, m_prev;
  int       m_ec, m_lap, m_dw;

  function automatic void add(bit r, bit v, bit c, bit [1:0] s,
      bit e, bit [1:0] ef, bit [1:0] et,
      int ec, int lap, int dw, bit to);
    vec_t x;
    x.r = r; x.v = v; x.c = c; x.s = s;
    x.e = e; x.ef = ef; x.et = et;
    x.ec = ec; x.lap = lap; x.dw = dw; x.to = to;
    tbl.push_back(x);
  endfunction

  task automatic apply(bit r, bit v, bit c, bit [1:0] s);
    @(negedge clock);
    reset = r; state_valid = v; clear = c; state_in = s;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string nm, bit e, bit [1:0] ef,
      bit [1:0] et, int ec, int lap, int dw, bit to);
    logic [AW-1:0] act, exp;
    act = {error, err_from, err_to, err_count, lap_count,
           dwell, dwell_timeout};
    exp = {e, ef, et, CW'(ec), CW'(lap), 8'(dw), to};
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got e=%0b from=%0d to=%0d ec=%0d lap=%0d dw=%0d tmo=%0b, want e=%0b from=%0d to=%0d ec=%0d lap=%0d dw=%0d tmo=%0b",
        nm, error, err_from, err_to, err_count, lap_count,
        dwell, dwell_timeout, e, ef, et, ec, lap, dw, to);
    end
  endtask

  // Reference: legality from modular distance of states.
  function automatic void model(bit r, bit v, bit c, bit [1:0] s);
    int d;
    bit legal;
    if (r) begin
      m_e = 0; m_ef = 0; m_et = 0; m_ec = 0; m_lap = 0;
      m_dw = 0; m_to = 0; m_prev = 0; m_seen = 0;
      return;
    end
    if (c) begin
      m_e = 0; m_ef = 0; m_et = 0; m_ec = 0; m_lap = 0;
      m_to = 0;
    end
    if (!v) return;
    d = (int'(s) - int'(m_prev) + 4) % 4;
    if (!m_seen) legal = (s == 0);
    else legal = (d == 1) || (!STRICT && d == 0);
    if (legal) begin
      if (m_seen && d == 0) begin
        if (m_dw == MD) m_to = 1;
        if (m_dw < 255) m_dw++;
      end else begin
        m_dw = 1;
      end
      if (m_seen && m_prev == 3 && s == 0)
        m_lap = (m_lap + 1) % (1 << CW);
    end else begin
      if (!m_e) begin m_ef = m_prev; m_et = s; end
      m_e = 1;
      if (m_ec < (1 << CW) - 1) m_ec++;
      m_dw = 1;
    end
    m_prev = s;
    m_seen = 1;
  endfunction

  initial begin
    bit r, v, c;
    bit [1:0] s;
    int k;

    // ---- vector table ----
    add(1,0,0,0, 0,0,0,0,0,0,0);
`ifdef STATE_SEQ_STRICT_EN
    add(0,1,0,0, 0,0,0,0,0,1,0);
    add(0,1,0,0, 1,0,0,1,0,1,0);
    add(0,1,0,1, 1,0,0,1,0,1,0);
    add(0,1,0,2, 1,0,0,1,0,1,0);
    add(0,1,0,3, 1,0,0,1,0,1,0);
    add(0,1,0,0, 1,0,0,1,1,1,0);
    add(0,1,0,0, 1,0,0,2,1,1,0);
    add(1,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,2, 1,0,2,1,0,1,0);
    add(1,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,1,0);
    add(0,1,0,1, 0,0,0,0,0,1,0);
    add(0,1,0,2, 0,0,0,0,0,1,0);
    add(0,1,0,0, 1,2,0,1,0,1,0);
`else
    add(0,1,0,0, 0,0,0,0,0,1,0);
    add(0,1,0,1, 0,0,0,0,0,1,0);
    add(0,1,0,2, 0,0,0,0,0,1,0);
    add(0,1,0,3, 0,0,0,0,0,1,0);
    add(0,1,0,0, 0,0,0,0,1,1,0);
    add(0,1,0,1, 0,0,0,0,1,1,0);
    add(1,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,1,0);
    add(0,1,0,1, 0,0,0,0,0,1,0);
    add(0,1,0,2, 0,0,0,0,0,1,0);
    add(0,1,0,0, 1,2,0,1,0,1,0);
    add(0,1,0,1, 1,2,0,1,0,1,0);
    add(0,1,0,2, 1,2,0,1,0,1,0);
    add(0,1,0,1, 1,2,0,2,0,1,0);
    add(1,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,2, 1,0,2,1,0,1,0);
    add(1,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,1,0);
    add(0,1,0,0, 0,0,0,0,0,2,0);
    add(0,1,0,0, 0,0,0,0,0,3,0);
    add(0,1,0,0, 0,0,0,0,0,4,1);
    add(0,1,0,1, 0,0,0,0,0,1,1);
    add(0,0,1,3, 0,0,0,0,0,1,0);
    add(0,1,1,1, 0,0,0,0,0,2,0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].s);
      chk($sformatf("vec%0d", i), tbl[i].e, tbl[i].ef,
          tbl[i].et, tbl[i].ec, tbl[i].lap, tbl[i].dw,
          tbl[i].to);
    end

    // ---- five laps, then STOP->IDLE with clear ----
    apply(1, 0, 0, 0);
    for (int l = 0; l < 6; l++)
      for (int q = 0; q < 4; q++)
        apply(0, 1, 0, 2'(q));
    chk("lap5", 0, 0, 0, 0, 5, 1, 0);
    apply(0, 1, 1, 0);
    chk("clr_lap", 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 2'($urandom_range(0, 3)));
      chk($sformatf("hold%0d", i), 0, 0, 0, 0, 1, 1, 0);
    end
    apply(0, 1, 1, 2);
    chk("clr_bad", 1, 0, 2, 1, 0, 1, 0);

`ifndef STATE_SEQ_STRICT_EN
    // ---- dwell saturation ----
    apply(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) apply(0, 1, 0, 0);
    chk("dw_sat", 0, 0, 0, 0, 0, 255, 1);
`endif

    // ---- randomized run against the model ----
    apply(1, 0, 0, 0);
    model(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 4);
      k = $urandom_range(0, 9);
      if (k < 6)      s = m_prev + 2'd1;
      else if (k < 8) s = m_prev;
      else            s = 2'($urandom_range(0, 3));
      apply(r, v, c, s);
      model(r, v, c, s);
      chk($sformatf("rnd%0d", i), m_e, m_ef, m_et, m_ec,
          m_lap, m_dw, m_to);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/state_seq_checker.md
Name: state_seq_checker

Overview:
- Downstream consumer of the 2-bit IDLE/START/RUN/STOP sequencer state output.
- Samples the state stream, checks that every step is a legal transition, and counts completed laps (STOP->IDLE).
- Tracks dwell time per state and flags illegal transitions and over-long dwells for debug/status logic.

Parameters:
- CNT_W, 16, width of lap_count and err_count.
- MAX_DWELL, 8, maximum legal consecutive valid samples in one state; range 1..255.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- state_in  input  2  sampled sequencer state (00 IDLE, 01 START, 10 RUN, 11 STOP).
- state_valid  input  1  state_in is sampled only when this is 1.
- clear  input  1  synchronous clear of flags and counters; does not affect tracking state.
- error  output  1  sticky illegal-transition flag.
- err_from  output  2  previous state of the first illegal transition.
- err_to  output  2  offending state of the first illegal transition.
- err_count  output  CNT_W  number of illegal samples; saturates at all-ones.
- lap_count  output  CNT_W  legal STOP->IDLE transitions; wraps modulo 2^CNT_W.
- dwell  output  8  consecutive valid samples in the current state; saturates at 255.
- dwell_timeout  output  1  sticky flag, set when dwell would exceed MAX_DWELL.

Behaviour:
- Reset: all outputs 0; internal prev_state = IDLE; internal seen = 0. Reset overrides clear and state_valid.
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N.
- state_valid = 0: nothing updates; all outputs and internal registers hold.
- Legality of a valid sample:
  - seen = 0: legal iff state_in == IDLE.
  - seen = 1: legal iff state_in == prev_state (hold) or state_in == prev_state + 1 mod 4 (advance).
  - Skips (e.g. IDLE->RUN) and reversals (e.g. RUN->START) are illegal.
- Legal sample:
  - prev_state <= state_in; seen <= 1.
  - Hold: dwell <= sat(dwell + 1). If dwell == MAX_DWELL before the increment, dwell_timeout <= 1.
  - Advance, or first sample: dwell <= 1.
  - STOP->IDLE advance: lap_count <= lap_count + 1 (wraps).
- Illegal sample:
  - error <= 1.
  - err_count <= sat(err_count + 1).
  - If error was 0: err_from <= prev_state (IDLE when seen = 0) and err_to <= state_in; later errors do not overwrite them.
  - prev_state <= state_in and seen <= 1 (resynchronise to the stream); dwell <= 1; lap_count unchanged.
- clear = 1:
  - error, err_from, err_to, err_count, lap_count, dwell_timeout <= 0.
  - dwell, prev_state and seen are unaffected.
  - If the same cycle has a valid sample, the sample's effects are applied on top of the cleared values. An illegal sample therefore leaves error = 1, err_count = 1 and fresh err_from/err_to. A legal STOP->IDLE leaves lap_count = 1.
- Reset mid-stream: the next valid sample must be IDLE; any other value is an illegal transition from IDLE.

Optional Feature:
- Macro STATE_SEQ_STRICT_EN.
- Defined: hold is illegal; every valid sample after the first must advance by exactly one. dwell stays at 1, and dwell_timeout is tied to 0. This matches a sequencer that advances every cycle.
- Undefined: hold is legal as described in Behaviour, and MAX_DWELL is enforced.

Decomposition:
- Shared package state_seq_pkg:
  - state_t 2-bit typedef.
  - Constants ST_IDLE, ST_START, ST_RUN, ST_STOP.
  - Function next_state(state_t) returning +1 mod 4.
  - Also used by the upstream sequencer.
- Sub-module seq_sat_counter (parameter W; inputs inc, clr, load1; saturating output). Instantiated for err_count and dwell.

Test Plan:
- Reset, then valid stream IDLE,START,RUN,STOP,IDLE,START → error = 0, lap_count = 1, dwell = 1.
- Valid stream IDLE,START,RUN,IDLE → error = 1, err_from = 10, err_to = 00, err_count = 1. Then START,RUN,START → err_count = 2; err_from/err_to still 10/00.
- First valid sample after reset is RUN → error = 1, err_from = 00, err_to = 10.
- MAX_DWELL = 3, stream IDLE×3 → dwell = 3, dwell_timeout = 0. A 4th IDLE → dwell = 4, dwell_timeout = 1. Then START → dwell = 1, dwell_timeout stays 1.
- Valid STOP→IDLE with clear = 1 in the same cycle, after lap_count = 5 → lap_count = 1, error = 0. Toggle state_valid = 0 for 3 cycles with garbage state_in → all outputs unchanged.
- Compile with STATE_SEQ_STRICT_EN, stream IDLE,IDLE → error = 1, err_from = 00, err_to = 00, dwell_timeout = 0.
